imem_port_arbiter: RTL and testbench

//  Shares the single-port, 1-cycle synchronous-read instruction memory between two requesters:
//   - fetch: read-only, from the core's fetch stage;
//   - loader: write-only, from the boot/debug program loader.

---
 rtl/imem_port_arbiter.sv | 107 ++++++++++
 tb/tb_imem_port_arbiter.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_port_arbiter.sv
// Shares a single-port, 1-cycle-read instruction memory between a read-only fetch port and a
// write-only program loader: fetch priority, bounded loader starvation, and a loader lock mode.
module imem_port_arbiter #(
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              f_valid,
   input  logic [31:0]       f_addr,
   output logic              f_ready,
   output logic              f_rvalid,
   output logic [DATA_W-1:0] f_rdata,
   output logic              f_err,
   input  logic              l_valid,
   input  logic [ADDR_W-1:0] l_addr,
   input  logic [DATA_W-1:0] l_wdata,
   input  logic              l_lock,
   output logic              l_ready,
   output logic              locked,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic {ARB, LOCK} state_t;

   localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

   state_t            state_q, state_d;
   logic [3:0]        wait_q, wait_d;
   logic              rvalid_q, rvalid_d;
   logic              err_q, err_d;
   logic              f_grant, l_grant;
   logic              f_bad;
   logic [ADDR_W-1:0] f_index;

   assign f_index = f_addr[ADDR_W+1:2];
   assign f_bad   = (f_addr[1:0] != 2'b00) || (f_addr[31:ADDR_W+2] != '0);

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      f_grant   = 1'b0;
      l_grant   = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (!reset) begin
         case (state_q)
            ARB: begin
               l_grant = l_valid && (!f_valid || (wait_q >= WAIT_LIM));
               f_grant = f_valid && !l_grant;
               if (l_lock && !f_grant) state_d = LOCK;
               if (l_grant || !l_valid) wait_d = '0;
               else if (wait_q < WAIT_LIM) wait_d = wait_q + 4'd1;
            end
            LOCK: begin
               l_grant = l_valid;
               wait_d  = '0;
               if (!l_lock) state_d = ARB;
            end
            default: state_d = ARB;
         endcase
         // A bad fetch is acknowledged but never reaches the array.
         if (f_grant) begin
            mem_en   = !f_bad;
            mem_addr = f_index;
         end
         if (l_grant) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = l_addr;
            mem_wdata = l_wdata;
         end
      end
   end

   assign rvalid_d = f_grant;
   assign err_d    = f_bad;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ARB;
         wait_q   <= '0;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
      end
   end

   assign f_ready  = f_grant;
   assign l_ready  = l_grant;
   assign locked   = (state_q == LOCK);
   assign f_rvalid = rvalid_q;
   assign f_err    = rvalid_q && err_q;
   assign f_rdata  = (rvalid_q && !err_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of the arbitration rules and the memory contents.
module tb_imem_port_arbiter;

   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 32;
   localparam int MAX_WAIT = 4;
   localparam int DEPTH    = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              reset;
   logic              f_valid;
   logic [31:0]       f_addr;
   logic              f_ready, f_rvalid, f_err;
   logic [DATA_W-1:0] f_rdata;
   logic              l_valid, l_lock, l_ready, locked;
   logic [ADDR_W-1:0] l_addr, mem_addr;
   logic [DATA_W-1:0] l_wdata, mem_wdata, mem_rdata;
   logic              mem_en, mem_we;

   logic [DATA_W-1:0] mem     [DEPTH];
   logic [DATA_W-1:0] ref_mem [DEPTH];

   int n_vec = 0;
   int n_err = 0;

   imem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset(reset),
      .f_valid(f_valid), .f_addr(f_addr), .f_ready(f_ready),
      .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err),
      .l_valid(l_valid), .l_addr(l_addr), .l_wdata(l_wdata), .l_lock(l_lock),
      .l_ready(l_ready), .locked(locked),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Single-port synchronous memory the arbiter fronts
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   task automatic idle();
      f_valid = 1'b0; f_addr = '0;
      l_valid = 1'b0; l_addr = '0; l_wdata = '0; l_lock = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      n_vec++;
      if ({f_ready, f_rvalid, f_err, l_ready, locked, mem_en, mem_we} !== 7'b0 || f_rdata !== '0)
      begin
         n_err++;
         $display("FAIL reset_idle: flags=%b rdata=%h, expected all zero",
                  {f_ready, f_rvalid, f_err, l_ready, locked, mem_en, mem_we}, f_rdata);
      end
      f_valid = 1'b1; f_addr = 32'h8; l_valid = 1'b1; l_lock = 1'b1; l_addr = 5'd3;
      l_wdata = 32'hFFFF_FFFF;
      #1;
      n_vec++;
      if ({f_ready, l_ready, locked, mem_en, mem_we} !== 5'b0 || mem_addr !== '0 || mem_wdata !== '0)
      begin
         n_err++;
         $display("FAIL reset_driven: flags=%b addr=%0d wdata=%h, expected all zero",
                  {f_ready, l_ready, locked, mem_en, mem_we}, mem_addr, mem_wdata);
      end
      @(negedge clk);
      idle();
      reset = 1'b0;
   endtask

   task automatic test_preload();
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         l_valid = 1'b1; l_addr = 5'(i); l_wdata = $urandom;
         ref_mem[i] = l_wdata;
         #1;
         n_vec++;
         if (l_ready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 5'(i)) begin
            n_err++;
            $display("FAIL preload[%0d]: l_ready=%b en=%b we=%b addr=%0d, expected 1 1 1 %0d",
                     i, l_ready, mem_en, mem_we, mem_addr, i);
         end
      end
      @(negedge clk);
      idle();
   endtask

   task automatic test_fetch();
      @(negedge clk);
      f_valid = 1'b1; f_addr = 32'h8;
      #1;
      n_vec++;
      if (f_ready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 5'd2) begin
         n_err++;
         $display("FAIL fetch_accept: f_ready=%b en=%b we=%b addr=%0d, expected 1 1 0 2",
                  f_ready, mem_en, mem_we, mem_addr);
      end
      @(posedge clk); #1;
      n_vec++;
      if (f_rvalid !== 1'b1 || f_err !== 1'b0 || f_rdata !== ref_mem[2]) begin
         n_err++;
         $display("FAIL fetch_resp: rvalid=%b err=%b rdata=%h, expected 1 0 %h",
                  f_rvalid, f_err, f_rdata, ref_mem[2]);
      end
      @(negedge clk);
      idle();
      @(posedge clk); #1;
      n_vec++;
      if (f_rvalid !== 1'b0) begin
         n_err++;
         $display("FAIL fetch_single_pulse: rvalid=%b, expected 0", f_rvalid);
      end
   endtask

   task automatic test_bad_fetch();
      logic [31:0] bad_a [2] = '{32'h6, 32'h80};
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         f_valid = 1'b1; f_addr = bad_a[i];
         #1;
         n_vec++;
         if (f_ready !== 1'b1 || mem_en !== 1'b0) begin
            n_err++;
            $display("FAIL bad_accept[%h]: f_ready=%b en=%b, expected 1 0", bad_a[i], f_ready, mem_en);
         end
         @(posedge clk); #1;
         n_vec++;
         if (f_rvalid !== 1'b1 || f_err !== 1'b1 || f_rdata !== '0) begin
            n_err++;
            $display("FAIL bad_resp[%h]: rvalid=%b err=%b rdata=%h, expected 1 1 0",
                     bad_a[i], f_rvalid, f_err, f_rdata);
         end
      end
      @(negedge clk);
      idle();
   endtask

   task automatic test_starvation();
      logic [31:0] wd  = $urandom;
      logic [31:0] wd2 = $urandom;
      logic        exp_l;
      @(negedge clk);
      f_valid = 1'b1; f_addr = 32'h10;
      l_valid = 1'b1; l_addr = 5'd7; l_wdata = wd;
      for (int k = 1; k <= MAX_WAIT + 1; k++) begin
         #1;
         exp_l = (k == MAX_WAIT + 1);
         n_vec++;
         if (l_ready !== exp_l || f_ready !== !exp_l ||
             (exp_l && (mem_we !== 1'b1 || mem_addr !== 5'd7 || mem_wdata !== wd))) begin
            n_err++;
            $display("FAIL starve_cycle%0d: l_ready=%b f_ready=%b we=%b addr=%0d, expected l_ready=%b",
                     k, l_ready, f_ready, mem_we, mem_addr, exp_l);
         end
         @(negedge clk);
      end
      ref_mem[7] = wd;
      f_addr = 32'h1C; l_addr = 5'd9; l_wdata = wd2;
      #1;
      n_vec++;
      if (f_ready !== 1'b1 || l_ready !== 1'b0) begin
         n_err++;
         $display("FAIL starve_resume: f_ready=%b l_ready=%b, expected 1 0", f_ready, l_ready);
      end
      @(posedge clk); #1;
      n_vec++;
      if (f_rvalid !== 1'b1 || f_rdata !== wd) begin
         n_err++;
         $display("FAIL starve_readback: rvalid=%b rdata=%h, expected 1 %h", f_rvalid, f_rdata, wd);
      end
      @(negedge clk);
      f_valid = 1'b0;
      #1;
      n_vec++;
      if (l_ready !== 1'b1 || mem_addr !== 5'd9) begin
         n_err++;
         $display("FAIL starve_nofetch: l_ready=%b addr=%0d, expected 1 9", l_ready, mem_addr);
      end
      ref_mem[9] = wd2;
      @(negedge clk);
      idle();
   endtask

   task automatic test_lock();
      @(negedge clk);
      f_valid = 1'b1; f_addr = 32'h0; l_lock = 1'b1;
      #1;
      n_vec++;
      if (f_ready !== 1'b1 || locked !== 1'b0) begin
         n_err++;
         $display("FAIL lock_fetch_first: f_ready=%b locked=%b, expected 1 0", f_ready, locked);
      end
      @(posedge clk); #1;
      n_vec++;
      if (f_rvalid !== 1'b1 || f_rdata !== ref_mem[0]) begin
         n_err++;
         $display("FAIL lock_fetch_resp: rvalid=%b rdata=%h, expected 1 %h", f_rvalid, f_rdata, ref_mem[0]);
      end
      @(negedge clk);
      f_valid = 1'b0;
      #1;
      n_vec++;
      if (locked !== 1'b0 || f_ready !== 1'b0) begin
         n_err++;
         $display("FAIL lock_deferred: locked=%b f_ready=%b, expected 0 0", locked, f_ready);
      end
      @(negedge clk);
      f_valid = 1'b1; f_addr = 32'hC;
      l_valid = 1'b1; l_addr = 5'd3; l_wdata = 32'hE3A0_0001;
      #1;
      n_vec++;
      if (locked !== 1'b1 || f_ready !== 1'b0 || l_ready !== 1'b1 || mem_we !== 1'b1 ||
          mem_addr !== 5'd3 || mem_wdata !== 32'hE3A0_0001) begin
         n_err++;
         $display("FAIL lock_write: locked=%b f_ready=%b l_ready=%b we=%b addr=%0d wdata=%h",
                  locked, f_ready, l_ready, mem_we, mem_addr, mem_wdata);
      end
      ref_mem[3] = 32'hE3A0_0001;
      @(negedge clk);
      l_valid = 1'b0;
      #1;
      n_vec++;
      if (locked !== 1'b1 || f_ready !== 1'b0 || l_ready !== 1'b0) begin
         n_err++;
         $display("FAIL lock_hold: locked=%b f_ready=%b l_ready=%b, expected 1 0 0", locked, f_ready, l_ready);
      end
      @(negedge clk);
      l_lock = 1'b0;
      #1;
      n_vec++;
      if (locked !== 1'b1 || f_ready !== 1'b0) begin
         n_err++;
         $display("FAIL lock_release_cycle: locked=%b f_ready=%b, expected 1 0", locked, f_ready);
      end
      @(negedge clk);
      #1;
      n_vec++;
      if (locked !== 1'b0 || f_ready !== 1'b1 || mem_addr !== 5'd3) begin
         n_err++;
         $display("FAIL lock_resume: locked=%b f_ready=%b addr=%0d, expected 0 1 3", locked, f_ready, mem_addr);
      end
      @(posedge clk); #1;
      n_vec++;
      if (f_rvalid !== 1'b1 || f_err !== 1'b0 || f_rdata !== 32'hE3A0_0001) begin
         n_err++;
         $display("FAIL lock_readback: rvalid=%b err=%b rdata=%h, expected 1 0 e3a00001",
                  f_rvalid, f_err, f_rdata);
      end
      @(negedge clk);
      idle();
   endtask

   task automatic test_reset_inflight();
      @(negedge clk);
      f_valid = 1'b1; f_addr = 32'h4;
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      n_vec++;
      if ({f_ready, f_rvalid, f_err, l_ready, locked, mem_en, mem_we} !== 7'b0 || f_rdata !== '0)
      begin
         n_err++;
         $display("FAIL reset_inflight: flags=%b rdata=%h, expected all zero",
                  {f_ready, f_rvalid, f_err, l_ready, locked, mem_en, mem_we}, f_rdata);
      end
      @(negedge clk);
      reset = 1'b0; f_addr = 32'h8;
      #1;
      n_vec++;
      if (f_rvalid !== 1'b0 || f_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_after: rvalid=%b f_ready=%b, expected 0 1", f_rvalid, f_ready);
      end
      @(posedge clk); #1;
      n_vec++;
      if (f_rvalid !== 1'b1 || f_rdata !== ref_mem[2]) begin
         n_err++;
         $display("FAIL reset_refetch: rvalid=%b rdata=%h, expected 1 %h", f_rvalid, f_rdata, ref_mem[2]);
      end
      @(negedge clk);
      idle();
      l_lock = 1'b1;
      @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      n_vec++;
      if (locked !== 1'b0) begin
         n_err++;
         $display("FAIL reset_from_lock: locked=%b, expected 0", locked);
      end
      @(negedge clk);
      reset = 1'b0; l_lock = 1'b0; f_valid = 1'b1; f_addr = 32'h8;
      #1;
      n_vec++;
      if (locked !== 1'b0 || f_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_state_arb: locked=%b f_ready=%b, expected 0 1", locked, f_ready);
      end
      @(negedge clk);
      idle();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         f_valid = 1'b1; f_addr = 32'(i * 4);
         #1;
         n_vec++;
         if (f_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_accept[%0d]: f_ready=%b, expected 1", i, f_ready);
         end
         @(posedge clk); #1;
         n_vec++;
         if (f_rvalid !== 1'b1 || f_rdata !== ref_mem[i]) begin
            n_err++;
            $display("FAIL b2b_resp[%0d]: rvalid=%b rdata=%h, expected 1 %h", i, f_rvalid, f_rdata, ref_mem[i]);
         end
      end
      @(negedge clk);
      idle();
      @(posedge clk); #1;
      n_vec++;
      if (f_rvalid !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_end: rvalid=%b, expected 0", f_rvalid);
      end
   endtask

   task automatic test_random(input int n);
      bit          m_locked = 1'b0;
      int          m_refused = 0;
      bit          hold_f = 1'b0, hold_l = 1'b0;
      bit          e_fr, e_lr, e_bad, p_valid, p_err;
      logic [31:0] p_data, fa_r;
      logic [4:0]  e_idx;
      int          sel;
      @(negedge clk);
      idle();
      reset = 1'b1;
      #2;
      reset = 1'b0;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         if (!hold_f) begin
            f_valid = ($urandom_range(0, 3) != 0);
            fa_r = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0)      f_addr = (fa_r & 32'h7C) | 32'h2;
            else if (sel == 1) f_addr = (fa_r & 32'hFFFF_FFFC) | 32'h80;
            else               f_addr = fa_r & 32'h7C;
         end
         if (!hold_l) begin
            l_valid = ($urandom_range(0, 2) == 0);
            l_addr  = 5'($urandom_range(0, DEPTH - 1));
            l_wdata = $urandom;
         end
         if ($urandom_range(0, 15) == 0) l_lock = !l_lock;
         e_bad = (f_addr % 4 != 0) || (f_addr >= 4 * DEPTH);
         e_idx = 5'(f_addr / 4);
         if (m_locked) begin
            e_fr = 1'b0;
            e_lr = l_valid;
         end else begin
            e_lr = l_valid && (!f_valid || m_refused >= MAX_WAIT);
            e_fr = f_valid && !e_lr;
         end
         #1;
         n_vec++;
         if (f_ready !== e_fr || l_ready !== e_lr || locked !== m_locked) begin
            n_err++;
            $display("FAIL rand_hs[%0d]: f_ready=%b l_ready=%b locked=%b, expected %b %b %b",
                     c, f_ready, l_ready, locked, e_fr, e_lr, m_locked);
         end
         n_vec++;
         if (mem_en !== (e_lr || (e_fr && !e_bad)) || mem_we !== e_lr ||
             (e_lr && (mem_addr !== l_addr || mem_wdata !== l_wdata)) ||
             (e_fr && !e_bad && mem_addr !== e_idx)) begin
            n_err++;
            $display("FAIL rand_mem[%0d]: en=%b we=%b addr=%0d wdata=%h, fetch=%b write=%b",
                     c, mem_en, mem_we, mem_addr, mem_wdata, e_fr, e_lr);
         end
         p_valid = e_fr;
         p_err   = e_bad;
         p_data  = e_bad ? 32'h0 : ref_mem[e_idx];
         @(posedge clk); #1;
         n_vec++;
         if (f_rvalid !== p_valid || (p_valid && (f_err !== p_err || f_rdata !== p_data))) begin
            n_err++;
            $display("FAIL rand_resp[%0d]: rvalid=%b err=%b rdata=%h, expected %b %b %h",
                     c, f_rvalid, f_err, f_rdata, p_valid, p_err, p_data);
         end
         if (e_lr) ref_mem[l_addr] = l_wdata;
         if (m_locked || !l_valid || e_lr) m_refused = 0;
         else if (m_refused < MAX_WAIT)    m_refused++;
         m_locked = m_locked ? l_lock : (l_lock && !e_fr);
         hold_f = f_valid && !e_fr;
         hold_l = l_valid && !e_lr;
      end
      @(negedge clk);
      idle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle();
      reset = 1'b1;
      test_reset();
      test_preload();
      test_fetch();
      test_bad_fetch();
      test_starvation();
      test_lock();
      test_reset_inflight();
      test_back_to_back();
      test_random(400);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
